// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M/RV64M multiply/divide unit.
//
// Sits beside the EXE-stage ALU. A request is accepted only in IDLE; the
// result is presented on resp_valid_o/result_o and held until resp_ready_i.
// busy_o is high whenever an operation is in flight (state != IDLE).
//
// Optional feature (compile-time macro): MULDIV_EARLY_OUT_EN
//   When defined, a division whose dividend magnitude is below the divisor
//   magnitude skips the iterative loop (quotient 0, remainder = dividend).
//
// Parameters:
//   XLEN       - datapath width, 32 or 64
//   DIV_BITS   - quotient bits retired per divider cycle, 1/2/4
//   MUL_STAGES - registered stages in the multiplier path, 1..3
//
// Ports:
//   clk          - clock
//   rst_n        - asynchronous active-low reset
//   flush_i      - kill in-flight op (synchronous, wins over handshakes)
//   req_valid_i  - request valid
//   req_ready_o  - unit idle and able to accept
//   op_i         - funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   word_i       - RV64 W variant (ignored when XLEN=32)
//   opr1_i       - rs1 value
//   opr2_i       - rs2 value
//   resp_valid_o - result valid
//   resp_ready_i - consumer accepts result
//   result_o     - result
//   busy_o       - operation in flight
`timescale 1ns/1ps
module muldiv_iter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DIV_BITS   = 1,
    parameter int unsigned MUL_STAGES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] opr1_i,
    input  logic [XLEN-1:0] opr2_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

    localparam int unsigned PW       = 2 * XLEN;
    localparam logic [6:0]  MUL_LAST = 7'(MUL_STAGES - 1);
    localparam logic [6:0]  ITER_X   = 7'(XLEN / DIV_BITS - 1);
    localparam logic [6:0]  ITER_W   = 7'(32 / DIV_BITS - 1);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return XLEN'($signed(x));
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
        return XLEN'(x);
    endfunction

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            word_q, word_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [PW-1:0]   pipe_q [MUL_STAGES];
    logic [PW-1:0]   pipe_d [MUL_STAGES];
    logic [XLEN-1:0] q_q, q_d;           // dividend shifting out / quotient shifting in
    logic [XLEN-1:0] r_q, r_d;           // partial remainder
    logic [XLEN-1:0] d_q, d_d;           // divisor magnitude
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] result_q, result_d;

    // ---------------- request front end (from inputs, used at accept) -------
    logic            word_eff;
    logic            a_sgn, b_sgn;
    logic [PW-1:0]   ma, mb, mul_full;
    logic            div_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_w, b_w, mag_a, mag_b, min_neg, q_init;

    assign word_eff = (XLEN == 64) && word_i;

    // Operands sign/zero-extended to 2*XLEN; the low 2*XLEN product bits are
    // then exact for every signedness combination.
    assign a_sgn    = ((op_i[1:0] == 2'd1) || (op_i[1:0] == 2'd2)) && opr1_i[XLEN-1];
    assign b_sgn    = (op_i[1:0] == 2'd1) && opr2_i[XLEN-1];
    assign ma       = {{XLEN{a_sgn}}, opr1_i};
    assign mb       = {{XLEN{b_sgn}}, opr2_i};
    assign mul_full = ma * mb;

    assign div_signed = ~op_i[0];
    assign a_w = word_eff ? (div_signed ? sext32(opr1_i[31:0]) : zext32(opr1_i[31:0])) : opr1_i;
    assign b_w = word_eff ? (div_signed ? sext32(opr2_i[31:0]) : zext32(opr2_i[31:0])) : opr2_i;
    assign a_neg    = div_signed & a_w[XLEN-1];
    assign b_neg    = div_signed & b_w[XLEN-1];
    assign mag_a    = a_neg ? (~a_w + XLEN'(1)) : a_w;
    assign mag_b    = b_neg ? (~b_w + XLEN'(1)) : b_w;
    assign div_zero = (b_w == '0);
    // Most-negative value of the active width, already sign-extended to XLEN.
    assign min_neg  = word_eff ? ({XLEN{1'b1}} << 31) : ({XLEN{1'b1}} << (XLEN - 1));
    assign div_ovf  = div_signed & (a_w == min_neg) & (b_w == '1);
    // W ops left-align the 32-bit dividend so the loop consumes its MSB first.
    assign q_init   = word_eff ? (mag_a << (XLEN - 32)) : mag_a;

    // ---------------- restoring divider step (DIV_BITS bits per cycle) ------
    logic [XLEN-1:0] step_q, step_r;
    logic [XLEN:0]   r_sh;

    always_comb begin
        step_q = q_q;
        step_r = r_q;
        r_sh   = '0;
        for (int unsigned i = 0; i < DIV_BITS; i++) begin
            r_sh   = {step_r, step_q[XLEN-1]};
            step_q = {step_q[XLEN-2:0], 1'b0};
            if (r_sh >= {1'b0, d_q}) begin
                r_sh      = r_sh - {1'b0, d_q};
                step_q[0] = 1'b1;
            end
            step_r = r_sh[XLEN-1:0];
        end
    end

    // ---------------- result selection ------------------------------------
    logic [PW-1:0]   mul_last;
    logic [XLEN-1:0] mul_sel, fix_raw, fix_val;

    assign mul_last = pipe_q[MUL_STAGES-1];
    // MULH/MULHSU/MULHU ignore word_q: only MUL has a W form.
    assign mul_sel  = (op_q[1:0] != 2'b00) ? mul_last[PW-1:XLEN] :
                      word_q ? sext32(mul_last[31:0]) : mul_last[XLEN-1:0];
    assign fix_raw  = op_q[1] ? (rneg_q ? (~r_q + XLEN'(1)) : r_q)
                              : (qneg_q ? (~q_q + XLEN'(1)) : q_q);
    assign fix_val  = word_q ? sext32(fix_raw[31:0]) : fix_raw;

    // ---------------- next-state logic ------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        pipe_d   = pipe_q;
        q_d      = q_q;
        r_d      = r_q;
        d_d      = d_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d   = op_i;
                    word_d = word_eff;
                    cnt_d  = '0;
                    if (!op_i[2]) begin
                        pipe_d[0] = mul_full;
                        state_d   = S_MUL;
                    end else begin
                        d_d     = mag_b;
                        r_d     = '0;
                        q_d     = q_init;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        state_d = S_DIV;
                        // Corner cases preload the final values and go
                        // straight to FIX with sign correction disabled.
                        if (div_zero) begin
                            q_d = '1;  r_d = a_w;
                            qneg_d = 1'b0; rneg_d = 1'b0;
                            state_d = S_FIX;
                        end else if (div_ovf) begin
                            q_d = a_w; r_d = '0;
                            qneg_d = 1'b0; rneg_d = 1'b0;
                            state_d = S_FIX;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        else if (mag_a < mag_b) begin
                            q_d = '0;  r_d = a_w;
                            qneg_d = 1'b0; rneg_d = 1'b0;
                            state_d = S_FIX;
                        end
`endif
                    end
                end
            end
            S_MUL: begin
                for (int unsigned i = 1; i < MUL_STAGES; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
                if (cnt_q == MUL_LAST) begin
                    result_d = mul_sel;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_DIV: begin
                q_d = step_q;
                r_d = step_r;
                if (cnt_q == (word_q ? ITER_W : ITER_X)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_FIX: begin
                result_d = fix_val;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    // ---------------- registers -------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            word_q   <= 1'b0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < MUL_STAGES; i++) begin
                pipe_q[i] <= '0;
            end
            q_q      <= '0;
            r_q      <= '0;
            d_q      <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            for (int unsigned i = 0; i < MUL_STAGES; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            q_q      <= q_d;
            r_q      <= r_d;
            d_q      <= d_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_DONE);
    assign busy_o       = (state_q != S_IDLE);
    assign result_o     = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
`timescale 1ns/1ps
module tb_muldiv_iter;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 34;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // XLEN=32, DIV_BITS=1, MUL_STAGES=1
    logic        flush32, v32, rdy32, word32, rv32, rr32, busy32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, res32;
    // XLEN=64, DIV_BITS=4, MUL_STAGES=2
    logic        flush64, v64, rdy64, word64, rv64, rr64, busy64;
    logic [2:0]  op64;
    logic [63:0] a64, b64, res64;

    int checks = 0;
    int errors = 0;

    muldiv_iter #(.XLEN(32), .DIV_BITS(1), .MUL_STAGES(1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush32),
        .req_valid_i(v32), .req_ready_o(rdy32), .op_i(op32), .word_i(word32),
        .opr1_i(a32), .opr2_i(b32), .resp_valid_o(rv32), .resp_ready_i(rr32),
        .result_o(res32), .busy_o(busy32)
    );

    muldiv_iter #(.XLEN(64), .DIV_BITS(4), .MUL_STAGES(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush64),
        .req_valid_i(v64), .req_ready_o(rdy64), .op_i(op64), .word_i(word64),
        .opr1_i(a64), .opr2_i(b64), .resp_valid_o(rv64), .resp_ready_i(rr64),
        .result_o(res64), .busy_o(busy64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_rv(input bit w64);
        return w64 ? rv64 : rv32;
    endfunction

    function automatic logic cur_busy(input bit w64);
        return w64 ? busy64 : busy32;
    endfunction

    function automatic logic [63:0] cur_res(input bit w64);
        return w64 ? res64 : {32'h0, res32};
    endfunction

    // Drive one request for one cycle; returns at the first negedge after accept.
    task automatic issue(input bit w64, input logic [2:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        if (w64) begin
            v64 = 1'b1; op64 = op; word64 = word; a64 = a; b64 = b;
        end else begin
            v32 = 1'b1; op32 = op; word32 = word; a32 = a[31:0]; b32 = b[31:0];
        end
        @(negedge clk);
        // Scramble operands: the unit must not re-sample them after accept.
        if (w64) begin
            v64 = 1'b0; a64 = ~a64; b64 = ~b64;
        end else begin
            v32 = 1'b0; a32 = ~a32; b32 = ~b32;
        end
    endtask

    task automatic run_op(input bit w64, input logic [2:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat, input string tag);
        int cyc;
        issue(w64, op, word, a, b);
        cyc = 1;
        while (!cur_rv(w64) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(lat));
        check({tag, "_res"}, cur_res(w64), exp);
        if (w64) rr64 = 1'b1; else rr32 = 1'b1;
        @(negedge clk);
        rr64 = 1'b0; rr32 = 1'b0;
        check({tag, "_idle"}, 64'(cur_busy(w64)), 64'd0);
    endtask

    initial begin
        int cyc;
        int hits;
        rst_n = 1'b0;
        flush32 = 0; v32 = 0; word32 = 0; rr32 = 0; op32 = '0; a32 = '0; b32 = '0;
        flush64 = 0; v64 = 0; word64 = 0; rr64 = 0; op64 = '0; a64 = '0; b64 = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(rdy32), 64'd1);
        check("rst_rvalid", 64'(rv32), 64'd0);
        check("rst_result", {32'h0, res32}, 64'd0);
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_result64", res64, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiplies, XLEN=32
        run_op(0, MULH,   0, 64'h80000000, 64'h80000000, 64'h40000000, 2, "mulh");
        run_op(0, MULHSU, 0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 2, "mulhsu");
        run_op(0, MULHU,  0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 2, "mulhu");
        run_op(0, MUL,    0, 64'h12345678, 64'h00000010, 64'h23456780, 2, "mul_lo");

        // Divides, XLEN=32, DIV_BITS=1
        run_op(0, DIV,  0, 64'hFFFFFFF9, 64'h2, 64'hFFFFFFFD, 34, "div_m7_2");
        run_op(0, REM,  0, 64'hFFFFFFF9, 64'h2, 64'hFFFFFFFF, 34, "rem_m7_2");
        run_op(0, REMU, 1, 64'h7,        64'h2, 64'h1,        34, "remu_7_2");
        run_op(0, DIV,  0, 64'h7, 64'hFFFFFFFE, 64'hFFFFFFFD, 34, "div_7_m2");
        run_op(0, REM,  0, 64'h7, 64'hFFFFFFFE, 64'h1,        34, "rem_7_m2");
        run_op(0, DIVU, 0, 64'hFFFFFFFF, 64'hFFFF, 64'h10001, 34, "divu_big");
        run_op(0, DIV,  0, 64'h80000000, 64'h2, 64'hC0000000, 34, "div_minneg_2");

        // Corner cases
        run_op(0, DIV, 0, 64'h5, 64'h0, 64'hFFFFFFFF, 2, "div_by0");
        run_op(0, REM, 0, 64'h5, 64'h0, 64'h5,        2, "rem_by0");
        run_op(0, DIV, 0, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 2, "div_ovf");
        run_op(0, REM, 0, 64'h80000000, 64'hFFFFFFFF, 64'h0,        2, "rem_ovf");

        // Early-out candidates (latency depends on the build)
        run_op(0, DIVU, 0, 64'h3, 64'hA, 64'h0, EO_LAT, "divu_3_10");
        run_op(0, REM, 0, 64'hFFFFFFFD, 64'hA, 64'hFFFFFFFD, EO_LAT, "rem_m3_10");

        // XLEN=64, DIV_BITS=4, MUL_STAGES=2
        run_op(1, DIV, 1, 64'h1_FFFFFFF0, 64'h4, 64'hFFFFFFFF_FFFFFFFC, 10, "divw");
        run_op(1, MUL, 1, 64'h7FFFFFFF, 64'h2, 64'hFFFFFFFF_FFFFFFFE, 3, "mulw");
        run_op(1, DIVU, 1, 64'h5_80000000, 64'h1, 64'hFFFFFFFF_80000000, 10, "divuw");
        run_op(1, REMU, 1, 64'h0_FFFFFFFF, 64'h10, 64'hF, 10, "remuw");
        run_op(1, DIV, 0, 64'hFFFFFFFF_FFFFFF9C, 64'h7, 64'hFFFFFFFF_FFFFFFF2, 18, "div64");
        run_op(1, MULHU, 0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF,
               64'hFFFFFFFF_FFFFFFFE, 3, "mulhu64");
        run_op(1, MULH, 1, 64'h80000000_00000000, 64'h2, 64'hFFFFFFFF_FFFFFFFF, 3, "mulh_word");
        run_op(1, DIV, 1, 64'h1_00000005, 64'hF_00000000, 64'hFFFFFFFF_FFFFFFFF, 2, "divw_by0");
        run_op(1, REM, 1, 64'h1_00000005, 64'hF_00000000, 64'h5, 2, "remw_by0");

        // Backpressure: hold the response for 5 cycles, request while busy
        issue(0, MUL, 0, 64'd6, 64'd7);
        cyc = 1;
        while (!rv32 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_lat", 64'(cyc), 64'd2);
        v32 = 1'b1; op32 = DIVU; a32 = 32'd9; b32 = 32'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_result", {32'h0, res32}, 64'd42);
            check("bp_ready", 64'(rdy32), 64'd0);
            check("bp_rvalid", 64'(rv32), 64'd1);
        end
        v32 = 1'b0; rr32 = 1'b1;
        @(negedge clk);
        rr32 = 1'b0;
        check("bp_rvalid_after", 64'(rv32), 64'd0);
        @(negedge clk);
        check("bp_no_late_accept", 64'(busy32), 64'd0);

        // Mid-operation asynchronous reset
        issue(1, DIV, 0, 64'd1000, 64'd3);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy64), 64'd0);
        check("arst_ready", 64'(rdy64), 64'd1);
        check("arst_result", res64, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Flush at DIV iteration 10
        issue(0, DIV, 0, 64'd100, 64'd3);
        repeat (10) @(negedge clk);
        flush32 = 1'b1;
        @(negedge clk);
        flush32 = 1'b0;
        check("flush_busy", 64'(busy32), 64'd0);
        check("flush_ready", 64'(rdy32), 64'd1);
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            if (rv32) hits++;
            @(negedge clk);
        end
        check("flush_no_resp", 64'(hits), 64'd0);
        run_op(0, MUL, 0, 64'd3, 64'd4, 64'd12, 2, "mul_after_flush");

        // Flush beats a same-cycle accept
        @(negedge clk);
        v32 = 1'b1; flush32 = 1'b1; op32 = DIV; a32 = 32'd5; b32 = 32'd0;
        @(negedge clk);
        v32 = 1'b0; flush32 = 1'b0;
        check("flush_acc_busy", 64'(busy32), 64'd0);
        @(negedge clk);
        check("flush_acc_rvalid", 64'(rv32), 64'd0);

        // Flush beats a same-cycle response handshake
        issue(0, MUL, 0, 64'd2, 64'd2);
        cyc = 1;
        while (!rv32 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("flush_done_lat", 64'(cyc), 64'd2);
        flush32 = 1'b1; rr32 = 1'b1;
        @(negedge clk);
        flush32 = 1'b0; rr32 = 1'b0;
        check("flush_done_rvalid", 64'(rv32), 64'd0);
        check("flush_done_busy", 64'(busy32), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
